// File: rtl/vld_rdy_trace_pkg.sv
// Shared types for the valid/ready trace player: record layout, FSM states
// and a saturating counter helper.
package vld_rdy_trace_pkg;

  localparam int TSW_DEF   = 64;
  localparam int DATAW_DEF = 8;

  typedef struct packed {
    logic [TSW_DEF-1:0]   ts;
    logic [DATAW_DEF-1:0] data;
    logic                 last;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } player_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trace_rec_fifo.sv
// First-word-fall-through record FIFO; o_head is valid whenever o_empty is low.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module trace_rec_fifo
  import vld_rdy_trace_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type rec_t = trace_rec_t
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  rec_t i_push_rec,
  input  logic i_pop,
  output rec_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  rec_t          r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_rec;
  end

endmodule

// File: rtl/vld_rdy_trace_player.sv
// Replays a timestamped valid/ready/data trace, either at the recorded cycle
// counts (timed) or back-to-back (untimed).
module vld_rdy_trace_player
  import vld_rdy_trace_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int TSW   = TSW_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             timed_mode,
  input  logic             rec_valid,
  output logic             rec_ready,
  input  logic [TSW-1:0]   rec_ts,
  input  logic [DATAW-1:0] rec_data,
  input  logic             rec_last,
  output logic             valid,
  input  logic             ready,
  output logic [DATAW-1:0] data,
  output logic [TSW-1:0]   clkcnt,
  output logic             busy,
  output logic             done,
  output logic [31:0]      xfer_cnt,
  output logic [31:0]      stall_cnt,
  output player_state_e    dbg_state
);

  typedef struct packed {
    logic [TSW-1:0]   ts;
    logic [DATAW-1:0] data;
    logic             last;
  } rec_t;

  player_state_e  r_state;
  logic [TSW-1:0] r_clkcnt;
  logic [31:0]    r_xfer_cnt;
  logic [31:0]    r_stall_cnt;
  logic           r_timed;

  rec_t w_push_rec;
  rec_t w_head;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_eligible;
  logic w_valid;

  // Both handshakes: a beat moves on a rising edge where valid && ready are
  // both high; valid never depends on ready and, once high, holds with its
  // payload until the beat is taken.
  assign w_push_rec = '{ts: rec_ts, data: rec_data, last: rec_last};
  assign w_push     = rec_valid && !w_full;
  assign w_eligible = !r_timed || (r_clkcnt >= w_head.ts);
  assign w_valid    = (r_state == RUN) && !w_empty && w_eligible;
  assign w_pop      = w_valid && ready;

  trace_rec_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_push     (w_push),
    .i_push_rec (w_push_rec),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_clkcnt    <= '0;
      r_xfer_cnt  <= '0;
      r_stall_cnt <= '0;
      r_timed     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // The FIFO is deliberately kept so a preload survives the restart.
          if (start) begin
            r_state     <= RUN;
            r_clkcnt    <= '0;
            r_xfer_cnt  <= '0;
            r_stall_cnt <= '0;
            r_timed     <= timed_mode;
          end
        end
        RUN: begin
          r_clkcnt <= r_clkcnt + 1'b1;
          if (w_pop) begin
            r_xfer_cnt <= sat_inc32(r_xfer_cnt);
            if (w_head.last) r_state <= DONE;
          end
          if (w_valid && !ready) r_stall_cnt <= sat_inc32(r_stall_cnt);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rec_ready = !w_full;
  assign valid     = w_valid;
  assign data      = w_valid ? w_head.data : '0;
  assign clkcnt    = r_clkcnt;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign xfer_cnt  = r_xfer_cnt;
  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_vld_rdy_trace_player.sv
// Bench for vld_rdy_trace_player: a trace-level model predicts when each
// record is offered and taken; a monitor checks every replay cycle.
module tb_vld_rdy_trace_player;
  import vld_rdy_trace_pkg::*;

  localparam int DATAW = 8;
  localparam int TSW   = 64;
  localparam int DEPTH = 4;
  localparam int NCYC  = 80;
  localparam int MAXR  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             timed_mode = 1'b0;
  logic             rec_valid = 1'b0;
  logic             rec_ready;
  logic [TSW-1:0]   rec_ts = '0;
  logic [DATAW-1:0] rec_data = '0;
  logic             rec_last = 1'b0;
  logic             valid;
  logic             ready = 1'b0;
  logic [DATAW-1:0] data;
  logic [TSW-1:0]   clkcnt;
  logic             busy;
  logic             done;
  logic [31:0]      xfer_cnt;
  logic [31:0]      stall_cnt;
  player_state_e    dbg_state;

  vld_rdy_trace_player #(.DATAW(DATAW), .TSW(TSW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .timed_mode (timed_mode),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_ts     (rec_ts),
    .rec_data   (rec_data),
    .rec_last   (rec_last),
    .valid      (valid),
    .ready      (ready),
    .data       (data),
    .clkcnt     (clkcnt),
    .busy       (busy),
    .done       (done),
    .xfer_cnt   (xfer_cnt),
    .stall_cnt  (stall_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Trace plan: records, push cycle (-1 = preloaded), ready pattern per cycle
  int               r_ts  [MAXR];
  logic [DATAW-1:0] r_dat [MAXR];
  int               r_pc  [MAXR];
  int               n_rec;
  bit               rdy_pat [NCYC];
  int               exp_rr  [NCYC];
  bit               exp_vld [NCYC];
  int               xstart_cyc;
  int               t_last;
  int               exp_stall;

  // Scoreboard
  logic [DATAW-1:0] exp_q[$];
  int               exp_t_q[$];
  int               tb_cyc = 0;
  bit               run_on = 1'b0;

  task automatic clear_plan();
    n_rec = 0;
    xstart_cyc = -1;
    for (int c = 0; c < NCYC; c++) begin
      rdy_pat[c] = 1'b1;
      exp_rr[c]  = 2;
      exp_vld[c] = 1'b0;
    end
    for (int i = 0; i < MAXR; i++) r_pc[i] = -1;
  endtask

  // Each record is offered from the first cycle it is at the head, present,
  // and (timed) due; it is taken at the first ready cycle from then on.
  task automatic build_model(input bit timed);
    int prev;
    int e;
    int t;
    int avail;
    exp_q.delete();
    exp_t_q.delete();
    exp_stall = 0;
    prev = -1;
    for (int i = 0; i < n_rec; i++) begin
      avail = (r_pc[i] < 0) ? 0 : r_pc[i] + 1;
      e = prev + 1;
      if (avail > e) e = avail;
      if (timed && r_ts[i] > e) e = r_ts[i];
      t = e;
      while (t < NCYC - 2 && !rdy_pat[t]) t++;
      for (int c = e; c <= t; c++) exp_vld[c] = 1'b1;
      exp_stall += t - e;
      exp_q.push_back(r_dat[i]);
      exp_t_q.push_back(t);
      if (r_pc[i] >= 0) exp_rr[r_pc[i]] = 1;
      prev = t;
    end
    t_last = prev;
  endtask

  // Driver tasks
  task automatic preload();
    for (int i = 0; i < n_rec; i++) begin
      if (r_pc[i] < 0) begin
        @(negedge clk);
        rec_valid = 1'b1;
        rec_ts    = TSW'(r_ts[i]);
        rec_data  = r_dat[i];
        rec_last  = (i == n_rec - 1);
      end
    end
    @(negedge clk);
    rec_valid = 1'b0;
  endtask

  task automatic run_trace(input bit timed);
    build_model(timed);
    @(negedge clk);
    start = 1'b1;
    timed_mode = timed;
    rec_valid = 1'b0;
    for (int c = 0; c <= t_last + 1; c++) begin
      @(negedge clk);
      start  = (c == xstart_cyc);
      tb_cyc = c;
      run_on = 1'b1;
      ready  = rdy_pat[c];
      rec_valid = 1'b0;
      for (int i = 0; i < n_rec; i++) begin
        if (r_pc[i] == c) begin
          rec_valid = 1'b1;
          rec_ts    = TSW'(r_ts[i]);
          rec_data  = r_dat[i];
          rec_last  = (i == n_rec - 1);
        end
      end
    end
    @(negedge clk);
    run_on = 1'b0;
    ready = 1'b0;
    rec_valid = 1'b0;
    start = 1'b0;
    #1;
    check("end_done", done, 1);
    check("end_xfer_cnt", xfer_cnt, n_rec);
    check("end_stall_cnt", stall_cnt, exp_stall);
    check("end_leftover", exp_q.size(), 0);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (run_on) begin
        check("clkcnt", clkcnt, tb_cyc);
        check("valid", valid, exp_vld[tb_cyc]);
        check("done", done, 64'(tb_cyc > t_last));
        check("busy", busy, 64'(tb_cyc <= t_last));
        if (tb_cyc == 0) begin
          check("start_xfer_clear", xfer_cnt, 0);
          check("start_stall_clear", stall_cnt, 0);
        end
        if (exp_rr[tb_cyc] != 2) check("rec_ready", rec_ready, exp_rr[tb_cyc]);
        if (valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_extra: got data 0x%0h at cycle %0d, expected no record", data, tb_cyc);
          end else begin
            check("data", data, exp_q[0]);
            if (ready) begin
              check("xfer_cycle", tb_cyc, exp_t_q[0]);
              void'(exp_q.pop_front());
              void'(exp_t_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rec_ready", rec_ready, 1);
    check("rst_data", data, 0);
    check("rst_clkcnt", clkcnt, 0);
    check("rst_xfer_cnt", xfer_cnt, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    // Timed replay, with a start pulse in RUN that must be ignored
    clear_plan();
    n_rec = 2;
    r_ts[0] = 3; r_dat[0] = 8'hA1;
    r_ts[1] = 5; r_dat[1] = 8'hB2;
    xstart_cyc = 2;
    preload();
    run_trace(1'b1);
    check("timed_done_clkcnt", clkcnt, 6);
    check("timed_xfer_cnt", xfer_cnt, 2);
    check("timed_stall_cnt", stall_cnt, 0);

    // Backpressure: ready low until clkcnt 6
    clear_plan();
    n_rec = 1;
    r_ts[0] = 2; r_dat[0] = 8'h4D;
    for (int c = 0; c < 6; c++) rdy_pat[c] = 1'b0;
    preload();
    run_trace(1'b1);
    check("bp_stall_cnt", stall_cnt, 4);

    // Untimed burst
    clear_plan();
    n_rec = 4;
    for (int i = 0; i < 4; i++) begin
      r_ts[i] = 100 + i;
      r_dat[i] = DATAW'(8'h11 * (i + 1));
    end
    preload();
    run_trace(1'b0);
    check("burst_done_clkcnt", clkcnt, 4);

    // Late record pushed into an empty FIFO during RUN
    clear_plan();
    n_rec = 1;
    r_ts[0] = 1; r_dat[0] = 8'h5C; r_pc[0] = 4;
    run_trace(1'b1);
    check("late_done_clkcnt", clkcnt, 6);

    // Full FIFO, pointer wrap, push+pop at occupancy 2
    clear_plan();
    n_rec = 7;
    for (int i = 0; i < 7; i++) begin
      r_ts[i] = 0;
      r_dat[i] = DATAW'(8'hC0 + i);
    end
    r_pc[4] = 2; r_pc[5] = 3; r_pc[6] = 4;
    rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b0;
    exp_rr[5] = 0;
    preload();
    #1;
    check("full_after_preload", rec_ready, 0);
    @(negedge clk);
    rec_valid = 1'b1; rec_data = 8'hEE; rec_ts = '0; rec_last = 1'b1;
    @(negedge clk);
    rec_valid = 1'b0;
    run_trace(1'b0);

    // Randomized traces, each restarting from DONE
    for (int k = 0; k < 12; k++) begin
      int ts;
      bit tm;
      clear_plan();
      n_rec = $urandom_range(1, 4);
      ts = $urandom_range(0, 5);
      for (int i = 0; i < n_rec; i++) begin
        r_ts[i] = ts;
        r_dat[i] = DATAW'($urandom_range(0, 255));
        ts += $urandom_range(0, 4);
      end
      for (int c = 0; c < 40; c++) rdy_pat[c] = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) xstart_cyc = 0;
      tm = 1'($urandom_range(0, 1));
      preload();
      run_trace(tm);
    end

    // Asynchronous reset while a record is being offered
    clear_plan();
    n_rec = 1;
    r_ts[0] = 0; r_dat[0] = 8'h3C;
    preload();
    @(negedge clk);
    start = 1'b1; timed_mode = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("rm_pre_valid", valid, 1);
    check("rm_pre_stall", stall_cnt, 1);
    #1;
    rst = 1'b0;
    #1;
    check("rm_valid", valid, 0);
    check("rm_rec_ready", rec_ready, 1);
    check("rm_busy", busy, 0);
    check("rm_clkcnt", clkcnt, 0);
    check("rm_xfer_cnt", xfer_cnt, 0);
    check("rm_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rm_state_idle", dbg_state, IDLE);
    clear_plan();
    n_rec = 1;
    r_ts[0] = 1; r_dat[0] = 8'h77;
    preload();
    run_trace(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vld_rdy_trace_player.md
Name: vld_rdy_trace_player

Overview:
- Replay side of the valid/ready/data trace agent: drives a valid/ready/data stream from a list of timestamped records.
- Each record is presented on the output when the player's cycle counter reaches the record's timestamp, or back-to-back in untimed mode.
- Used in the hwemu flow to re-inject a recorded producer stream into a DUT input, using the same clock-count convention as the tracer.

Parameters:
- DATAW, 8, payload width.
- TSW, 64, timestamp and cycle-counter width (matches a longint clock count).
- DEPTH, 4, record FIFO depth; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- start  in  1  single-cycle pulse; begins replay.
- timed_mode  in  1  1 = honour timestamps, 0 = issue back-to-back; sampled on start.
- rec_valid  in  1  record load handshake, valid.
- rec_ready  out  1  record load handshake, ready.
- rec_ts  in  TSW  record timestamp (cycle count of the original transfer).
- rec_data  in  DATAW  record payload.
- rec_last  in  1  final record of the trace.
- valid  out  1  replayed stream, valid.
- ready  in  1  replayed stream, ready (from the DUT).
- data  out  DATAW  replayed stream, payload.
- clkcnt  out  TSW  replay cycle counter.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- xfer_cnt  out  32  completed output transfers.
- stall_cnt  out  32  cycles with valid=1 and ready=0.

Behaviour:
- Reset: state IDLE, FIFO empty, clkcnt=0, counters=0, timed latch=0. Outputs after reset: valid=0, busy=0, done=0, rec_ready=1. data is don't-care but driven to 0.
- FIFO:
  - rec_ready = !full, registered-state only.
  - A push occurs when rec_valid && rec_ready. Pushes are accepted in any state, so the FIFO can be preloaded in IDLE.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
- States IDLE, RUN, DONE.
  - IDLE: start -> RUN. In that transition clkcnt:=0, xfer_cnt:=0, stall_cnt:=0, and timed latch:=timed_mode. The FIFO is not flushed.
  - RUN: clkcnt increments by 1 every cycle and wraps at 2^TSW.
  - DONE: clkcnt holds. start -> RUN, with the same clears as from IDLE.
  - start in RUN is ignored.
- valid = (state==RUN) && !empty && (!timed || clkcnt >= head.ts). It is combinational from registers only; there is no path from ready to valid.
  - With timed=1, a record with ts=T raises valid in the cycle where clkcnt==T, giving zero latency relative to the counter.
  - A late record (ts < clkcnt) is issued immediately.
  - data = head.data whenever valid=1.
  - Once valid rises, valid and data hold until ready. The timed latch and clkcnt are monotonic, so the eligibility condition cannot drop.
- Transfer (valid && ready):
  - Pop the head and increment xfer_cnt (saturating).
  - If head.last, go to DONE on the next edge; valid falls.
  - Otherwise the next head may be presented in the following cycle if it is eligible, so one transfer per cycle is sustained.
- stall_cnt increments (saturating) each cycle with valid && !ready.
- RUN with an empty FIFO: valid=0, clkcnt keeps counting. This is an underrun; no error flag is raised.
- rst asserted mid-replay: everything returns to reset values immediately, including FIFO contents.

Decomposition:
- Package vld_rdy_trace_pkg:
  - trace_rec_t struct {ts[TSW], data[DATAW], last}.
  - player_state_e enum {IDLE, RUN, DONE}.
  - Default TSW constant.
- One sub-module: trace_rec_fifo, a parameterised synchronous FIFO of trace_rec_t with full, empty and head outputs, first-word-fall-through.

Test Plan:
- Timed replay: preload ts=3/data=0xA1, ts=5/data=0xB2/last, ready=1, timed_mode=1, pulse start -> valid high exactly when clkcnt==3 (data 0xA1) and when clkcnt==5 (data 0xB2). done=1 the cycle after the second transfer; xfer_cnt=2, stall_cnt=0.
- Backpressure: one record ts=2, ready held 0 until clkcnt==6 -> valid and data stable over clkcnt 2..6; transfer at clkcnt 6; stall_cnt=4.
- Untimed burst: four records ts=100..103, timed_mode=0, ready=1 -> valid high four consecutive cycles from clkcnt 0; data in push order; done after the last record.
- Late/underrun and wrap: records pushed in RUN after clkcnt already exceeds ts=1 -> issued the cycle after the push. With DEPTH=4, push 6 records while draining -> rec_ready drops at full, FIFO order is preserved across pointer wrap, and a simultaneous push/pop at occupancy 2 leaves it at 2.
- Reset mid-operation: assert rst while valid=1 -> valid=0 and rec_ready=1 immediately (asynchronous); counters=0; after release the block is in IDLE and a fresh start replays the new preload.
- Restart from DONE: start in DONE -> clkcnt, xfer_cnt and stall_cnt cleared and replay resumes; a start pulse in RUN has no effect on clkcnt.
